// File: rtl/pwl_table_writer_pkg.sv
// Shared types and helpers for the piecewise-linear coefficient table writer
// and the evaluator that decodes the same RAM word layout.
package pwl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } pwl_state_e;

  // Widest offset or slope field that pack_word can place into a RAM word.
  localparam int unsigned max_field_width = 32;

  // Wide enough that slope * 2**segment_width summed over any table cannot wrap.
  function automatic int unsigned acc_width(input int unsigned offset_width,
                                            input int unsigned slope_width,
                                            input int unsigned segment_width);
    return offset_width + slope_width + segment_width + 1;
  endfunction

  // RAM word = {offset, slope}, offset in the MSBs. Both fields arrive
  // zero-extended to max_field_width; the caller truncates to its word width.
  function automatic logic [2*max_field_width-1:0] pack_word(
      input logic [max_field_width-1:0] offset,
      input logic [max_field_width-1:0] slope,
      input int unsigned                slope_width);
    return ({{max_field_width{1'b0}}, offset} << slope_width)
         | {{max_field_width{1'b0}}, slope};
  endfunction

endpackage

// File: rtl/pwl_table_writer_if.sv
// Slope stream in, coefficient RAM write port out. The master side is the
// host plus RAM; the slave side is the table writer.
interface pwl_table_writer_if #(
  parameter int unsigned addr_width   = 4,
  parameter int unsigned offset_width = 18,
  parameter int unsigned slope_width  = 18
);

  logic [slope_width-1:0]              s_slope;
  logic                                s_valid;
  logic                                s_ready;
  logic                                wr_en;
  logic [addr_width-1:0]               wr_addr;
  logic [offset_width+slope_width-1:0] wr_data;

  modport master (
    output s_slope,
    output s_valid,
    input  s_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  s_slope,
    input  s_valid,
    output s_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

endinterface

// File: rtl/pwl_delta.sv
// Offset increment contributed by one segment: floor(slope * 2**segment_width
// / 2**delta_shift), computed at accumulator width so nothing is lost.
module pwl_delta #(
  parameter int unsigned slope_width   = 18,
  parameter int unsigned segment_width = 8,
  parameter int unsigned delta_shift   = 8,
  parameter int unsigned delta_width   = 45
) (
  input  logic signed [slope_width-1:0] slope,
  output logic signed [delta_width-1:0] delta
);

  logic signed [delta_width-1:0] slope_ext;

  // Signed operands keep both the widening cast and >>> sign-preserving (floor).
  assign slope_ext = delta_width'(slope);
  assign delta     = (slope_ext <<< segment_width) >>> delta_shift;

endmodule

// File: rtl/pwl_table_writer.sv
// Integrates a stream of per-segment slopes into continuous offsets and writes
// packed {offset, slope} words to sequential coefficient RAM addresses.
module pwl_table_writer
  import pwl_pkg::*;
#(
  parameter int unsigned addr_width    = 4,
  parameter int unsigned segment_width = 8,
  parameter int unsigned offset_width  = 18,
  parameter int unsigned slope_width   = 18,
  parameter int unsigned delta_shift   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic signed [offset_width-1:0] init_offset,
  pwl_table_writer_if.slave              bus,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow
);

  localparam int unsigned acc_w      = acc_width(offset_width, slope_width, segment_width);
  localparam int unsigned word_width = offset_width + slope_width;
  localparam logic [addr_width-1:0] last_addr = '1;

  pwl_state_e              state;
  logic [addr_width-1:0]   cnt;
  logic signed [acc_w-1:0] acc;
  logic signed [acc_w-1:0] delta;
  logic                    handshake;
  logic [acc_w-offset_width:0] acc_hi;
  logic                    acc_in_range;

  pwl_delta #(
    .slope_width  (slope_width),
    .segment_width(segment_width),
    .delta_shift  (delta_shift),
    .delta_width  (acc_w)
  ) u_delta (
    .slope(bus.s_slope),
    .delta(delta)
  );

  assign handshake = bus.s_valid & bus.s_ready;

  // acc fits the signed offset field exactly when every bit from the field's
  // sign bit upward is identical.
  assign acc_hi       = acc[acc_w-1:offset_width-1];
  assign acc_in_range = (&acc_hi) | ~(|acc_hi);

  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; blocking = would let later lines see new values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bus.s_ready <= 1'b0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
    end else begin
      bus.wr_en <= 1'b0;
      done      <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state       <= LOAD;
            acc         <= acc_w'(init_offset);
            cnt         <= '0;
            overflow    <= 1'b0;
            bus.s_ready <= 1'b1;
            busy        <= 1'b1;
          end
        end

        LOAD: begin
          if (handshake) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= cnt;
            bus.wr_data <= word_width'(pack_word(max_field_width'(acc[offset_width-1:0]),
                                                 max_field_width'(bus.s_slope),
                                                 slope_width));
            acc <= acc + delta;
            cnt <= cnt + 1'b1;
            if (!acc_in_range) begin
              overflow <= 1'b1;
            end
            // The last word's write cycle is the DONE cycle itself.
            if (cnt == last_addr) begin
              state       <= DONE;
              bus.s_ready <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwl_table_writer.sv
// Scoreboard bench for pwl_table_writer: two instances, delta_shift 4 (delta
// equals slope) and delta_shift 6 (floor scaling), both with a 4-entry table.
module tb_pwl_table_writer;

  localparam int unsigned aw  = 2;
  localparam int unsigned sgw = 4;
  localparam int unsigned ow  = 8;
  localparam int unsigned sw  = 8;

  typedef struct {
    int              cyc;
    logic [aw-1:0]   addr;
    logic [15:0]     data;
    bit              last;
    bit              ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic signed [ow-1:0] init_a = '0, init_b = '0;
  logic busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];

  pwl_table_writer_if #(.addr_width(aw), .offset_width(ow), .slope_width(sw)) bus_a ();
  pwl_table_writer_if #(.addr_width(aw), .offset_width(ow), .slope_width(sw)) bus_b ();

  pwl_table_writer #(
    .addr_width(aw), .segment_width(sgw), .offset_width(ow), .slope_width(sw), .delta_shift(4)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .init_offset(init_a), .bus(bus_a.slave),
    .busy(busy_a), .done(done_a), .overflow(ovf_a)
  );

  pwl_table_writer #(
    .addr_width(aw), .segment_width(sgw), .offset_width(ow), .slope_width(sw), .delta_shift(6)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .init_offset(init_b), .bus(bus_b.slave),
    .busy(busy_b), .done(done_b), .overflow(ovf_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic compare_write(input string tag, input exp_t e, input logic [aw-1:0] addr,
                               input logic [15:0] data, input logic dn, input logic bz,
                               input logic ov);
    check({tag, "_cycle"}, cyc, e.cyc);
    check({tag, "_addr"}, 32'(addr), 32'(e.addr));
    check({tag, "_data"}, 32'(data), 32'(e.data));
    check({tag, "_done"}, 32'(dn), 32'(e.last));
    check({tag, "_busy"}, 32'(bz), 32'(!e.last));
    check({tag, "_overflow"}, 32'(ov), 32'(e.ovf));
  endtask

  // Monitors: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus_a.wr_en === 1'b1) begin
      if (exp_a.size() == 0) check("a_unexpected_write", 32'(bus_a.wr_addr), 32'hFFFF_FFFF);
      else compare_write("a_wr", exp_a.pop_front(), bus_a.wr_addr, bus_a.wr_data,
                         done_a, busy_a, ovf_a);
    end else if (done_a === 1'b1) begin
      check("a_done_without_write", 32'(bus_a.wr_en), 32'd1);
    end
  end

  always @(negedge clk) begin
    if (bus_b.wr_en === 1'b1) begin
      if (exp_b.size() == 0) check("b_unexpected_write", 32'(bus_b.wr_addr), 32'hFFFF_FFFF);
      else compare_write("b_wr", exp_b.pop_front(), bus_b.wr_addr, bus_b.wr_data,
                         done_b, busy_b, ovf_b);
    end else if (done_b === 1'b1) begin
      check("b_done_without_write", 32'(bus_b.wr_en), 32'd1);
    end
  end

  task automatic drive(input int d, input logic v, input logic [sw-1:0] s);
    if (d == 0) begin bus_a.s_valid = v; bus_a.s_slope = s; end
    else begin bus_b.s_valid = v; bus_b.s_slope = s; end
  endtask

  function automatic logic ready(input int d);
    return (d == 0) ? bus_a.s_ready : bus_b.s_ready;
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Pulse start, then confirm the writer has entered LOAD with overflow clear.
  task automatic start_load(input int d, input logic signed [ow-1:0] init);
    if (d == 0) begin start_a = 1'b1; init_a = init; end
    else begin start_b = 1'b1; init_b = init; end
    step(1);
    start_a = 1'b0;
    start_b = 1'b0;
    check("start_busy", 32'(d == 0 ? busy_a : busy_b), 32'd1);
    check("start_s_ready", 32'(ready(d)), 32'd1);
    check("start_overflow_clear", 32'(d == 0 ? ovf_a : ovf_b), 32'd0);
  endtask

  // One slope handshake; the expected write is queued for the cycle after it.
  task automatic send(input int d, input logic [sw-1:0] slope, input logic [aw-1:0] addr,
                      input logic [ow-1:0] offset, input bit last, input bit ovf);
    int waited = 0;
    exp_t e;
    drive(d, 1'b1, slope);
    while (ready(d) !== 1'b1 && waited < 20) begin
      step(1);
      waited++;
    end
    check("s_ready_before_handshake", 32'(ready(d)), 32'd1);
    e.cyc  = cyc + 1;
    e.addr = addr;
    e.data = {offset, slope};
    e.last = last;
    e.ovf  = ovf;
    if (d == 0) exp_a.push_back(e);
    else exp_b.push_back(e);
    step(1);
    drive(d, 1'b0, 8'h5A);
  endtask

  initial begin
    bus_a.s_valid = 1'b0; bus_a.s_slope = '0;
    bus_b.s_valid = 1'b0; bus_b.s_slope = '0;
    step(2);
    check("rst_s_ready", 32'(bus_a.s_ready), 32'd0);
    check("rst_wr_en", 32'(bus_a.wr_en), 32'd0);
    check("rst_wr_addr", 32'(bus_a.wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus_a.wr_data), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_overflow", 32'(ovf_a), 32'd0);
    check("rst_b_busy", 32'(busy_b), 32'd0);
    rst = 1'b0;
    step(1);

    // Floor scaling: -3 -> -1, +3 -> 0. The mid-load start must be ignored.
    start_load(1, 8'sd5);
    send(1, 8'hFD, 2'd0, 8'd5, 1'b0, 1'b0);
    start_b = 1'b1; init_b = 8'sd100;
    step(1);
    start_b = 1'b0;
    check("b_ignored_start_busy", 32'(busy_b), 32'd1);
    send(1, 8'hFD, 2'd1, 8'd4, 1'b0, 1'b0);
    send(1, 8'h03, 2'd2, 8'd3, 1'b0, 1'b0);
    send(1, 8'h00, 2'd3, 8'd3, 1'b1, 1'b0);
    step(2);

    // Basic back-to-back load.
    start_load(0, 8'sd10);
    send(0, 8'h03, 2'd0, 8'd10, 1'b0, 1'b0);
    send(0, 8'hFB, 2'd1, 8'd13, 1'b0, 1'b0);
    send(0, 8'h07, 2'd2, 8'd8,  1'b0, 1'b0);
    send(0, 8'h00, 2'd3, 8'd15, 1'b1, 1'b0);
    check("a_s_ready_after_last", 32'(bus_a.s_ready), 32'd0);
    step(1);
    check("a_done_one_cycle", 32'(done_a), 32'd0);
    step(1);

    // Same slopes with two idle cycles between handshakes.
    start_load(0, 8'sd10);
    send(0, 8'h03, 2'd0, 8'd10, 1'b0, 1'b0);
    step(2);
    send(0, 8'hFB, 2'd1, 8'd13, 1'b0, 1'b0);
    step(2);
    send(0, 8'h07, 2'd2, 8'd8,  1'b0, 1'b0);
    step(2);
    send(0, 8'h00, 2'd3, 8'd15, 1'b1, 1'b0);
    step(2);

    // Overflow: 130 wraps to 0x82 and the flag sticks through done.
    start_load(0, 8'sd120);
    send(0, 8'h0A, 2'd0, 8'h78, 1'b0, 1'b0);
    send(0, 8'h0A, 2'd1, 8'h82, 1'b0, 1'b1);
    send(0, 8'h00, 2'd2, 8'h8C, 1'b0, 1'b1);
    send(0, 8'h00, 2'd3, 8'h8C, 1'b1, 1'b1);
    step(2);
    check("overflow_sticky_idle", 32'(ovf_a), 32'd1);

    // Reset after the second handshake aborts the load; start clears overflow.
    start_load(0, 8'sd10);
    send(0, 8'h03, 2'd0, 8'd10, 1'b0, 1'b0);
    send(0, 8'hFB, 2'd1, 8'd13, 1'b0, 1'b0);
    rst = 1'b1;
    step(1);
    check("midrst_s_ready", 32'(bus_a.s_ready), 32'd0);
    check("midrst_wr_en", 32'(bus_a.wr_en), 32'd0);
    check("midrst_wr_addr", 32'(bus_a.wr_addr), 32'd0);
    check("midrst_wr_data", 32'(bus_a.wr_data), 32'd0);
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_done", 32'(done_a), 32'd0);
    check("midrst_overflow", 32'(ovf_a), 32'd0);
    rst = 1'b0;
    drive(0, 1'b1, 8'h07);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("idle_s_ready", 32'(bus_a.s_ready), 32'd0);
    end
    drive(0, 1'b0, 8'h00);
    step(1);

    start_load(0, 8'sd0);
    send(0, 8'h01, 2'd0, 8'd0, 1'b0, 1'b0);
    send(0, 8'h01, 2'd1, 8'd1, 1'b0, 1'b0);
    send(0, 8'h01, 2'd2, 8'd2, 1'b0, 1'b0);
    send(0, 8'h01, 2'd3, 8'd3, 1'b1, 1'b0);
    step(3);

    check("a_queue_drained", exp_a.size(), 32'd0);
    check("b_queue_drained", exp_b.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
